cnn_sequencer: RTL and testbench

- Top-level controller for the digit-classifier datapath.
- Streams pixel addresses to the image loader, then sequences the conv, relu, flatten, fully-connected and classify stages one at a time with start/done handshakes.
- Latches the 4-bit class result and raises completion.
- Sits between the host/top-level control and the Conv pipeline; owns all stage enables and the image address counter.

---
 rtl/cnn_sequencer_pkg.sv | 40 ++++
 rtl/cnn_sequencer_if.sv | 30 +++
 rtl/cnn_seq_watchdog.sv | 42 ++++
 rtl/cnn_sequencer.sv | 148 ++++++++++++++
 tb/tb_cnn_sequencer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_sequencer_pkg.sv
// Shared types and constants for the digit-classifier control path.
package cnn_pkg;

  localparam int NUM_PIXELS = 256;  // 16x16 image
  localparam int ADDR_W     = 8;    // NUM_PIXELS == 2**ADDR_W
  localparam int NUM_STAGES = 5;    // conv, relu, flatten, fc, classify
  localparam int TIMEOUT_W  = 16;
  localparam int CLASS_W    = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    KICK,
    WAIT,
    STORE,
    ERROR
  } seq_state_t;

  typedef enum logic [2:0] {
    ST_CONV  = 3'd0,
    ST_RELU  = 3'd1,
    ST_FLAT  = 3'd2,
    ST_FC    = 3'd3,
    ST_CLASS = 3'd4
  } stage_idx_t;

  // One-hot start vector for a stage index.
  function automatic logic [NUM_STAGES-1:0] stage_onehot(input stage_idx_t k);
    logic [NUM_STAGES-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // Next stage in the fixed pipeline order.
  function automatic stage_idx_t stage_next(input stage_idx_t k);
    return stage_idx_t'(k + 3'd1);
  endfunction

endpackage

// File: rtl/cnn_sequencer_if.sv
// Host, image-loader and stage handshake bundle for the sequencer.
interface cnn_sequencer_if;

  logic                           start;
  logic                           abort;
  logic [cnn_pkg::TIMEOUT_W-1:0]  timeout_cycles;
  logic [cnn_pkg::ADDR_W-1:0]     img_addr;
  logic                           img_valid;
  logic                           img_ready;
  logic [cnn_pkg::NUM_STAGES-1:0] stage_start;
  logic [cnn_pkg::NUM_STAGES-1:0] stage_done;
  logic [cnn_pkg::CLASS_W-1:0]    class_in;
  logic [cnn_pkg::CLASS_W-1:0]    result;
  logic                           result_valid;
  logic                           busy;
  logic                           error;

  // Sequencer side.
  modport master (
    input  start, abort, timeout_cycles, img_ready, stage_done, class_in,
    output img_addr, img_valid, stage_start, result, result_valid, busy, error
  );

  // Host / datapath side.
  modport slave (
    output start, abort, timeout_cycles, img_ready, stage_done, class_in,
    input  img_addr, img_valid, stage_start, result, result_valid, busy, error
  );

endinterface

// File: rtl/cnn_seq_watchdog.sv
// Per-stage watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches a nonzero limit. A limit of zero
// disables the flag. The counter saturates instead of wrapping.
module cnn_seq_watchdog #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W-1:0] count_inc;

  // Next count: clear wins, otherwise count enabled cycles up to saturation.
  always_comb begin
    count_inc = count_q + 1'b1;
    count_d   = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_inc;
    end
  end

  // Expiry is flagged in the enabled cycle that brings the count to the limit.
  assign expired = en && !clr && (limit != '0) && (count_inc == limit);

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cnn_sequencer.sv
// Top-level sequencer: streams the image addresses to the loader, then
// kicks each compute stage in order and waits for its done pulse, latching
// the class result at the end. All outputs come straight from flops.
module cnn_sequencer
  import cnn_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  cnn_sequencer_if.master bus
);

  seq_state_t              state_q, state_d;
  stage_idx_t              stage_q, stage_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [CLASS_W-1:0]      result_q, result_d;
  logic                    error_q, error_d;
  logic                    img_valid_q, img_valid_d;
  logic                    busy_q, busy_d;
  logic                    result_valid_q, result_valid_d;
  logic [NUM_STAGES-1:0]   stage_start_q, stage_start_d;

  logic                    wd_clr;
  logic                    wd_en;
  logic                    wd_expired;
  logic                    done_k;
  logic                    last_pixel;

  // Only the done bit of the stage currently being waited on matters.
  assign done_k     = bus.stage_done[stage_q];
  assign last_pixel = (addr_q == ADDR_W'(NUM_PIXELS - 1));

  cnn_seq_watchdog #(
    .W (TIMEOUT_W)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .limit   (bus.timeout_cycles),
    .expired (wd_expired)
  );

  // Next-state and next-output logic; outputs are derived from the next state
  // so they line up with the state they describe.
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    addr_d   = addr_q;
    result_d = result_q;
    error_d  = error_q;
    wd_clr   = 1'b0;
    wd_en    = 1'b0;

    if (bus.abort) begin
      // Abort beats everything, including a coincident final done.
      state_d = IDLE;
      stage_d = ST_CONV;
      addr_d  = '0;
      error_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, ERROR: begin
          if (bus.start) begin
            state_d = LOAD;
            stage_d = ST_CONV;
            addr_d  = '0;
            error_d = 1'b0;
          end
        end
        LOAD: begin
          if (bus.img_ready) begin
            // Natural wrap returns the address to 0 after the last pixel.
            addr_d = addr_q + 1'b1;
            if (last_pixel) begin
              state_d = KICK;
              stage_d = ST_CONV;
            end
          end
        end
        KICK: begin
          wd_clr  = 1'b1;
          state_d = WAIT;
        end
        WAIT: begin
          wd_en = 1'b1;
          if (done_k) begin
            if (stage_q == ST_CLASS) begin
              result_d = bus.class_in;
              state_d  = STORE;
            end else begin
              stage_d = stage_next(stage_q);
              state_d = KICK;
            end
          end else if (wd_expired) begin
            state_d = ERROR;
            error_d = 1'b1;
          end
        end
        STORE: begin
          state_d = IDLE;
          stage_d = ST_CONV;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    img_valid_d    = (state_d == LOAD);
    busy_d         = (state_d != IDLE) && (state_d != ERROR);
    result_valid_d = (state_d == STORE);
    stage_start_d  = (state_d == KICK) ? stage_onehot(stage_d) : '0;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      stage_q        <= ST_CONV;
      addr_q         <= '0;
      result_q       <= '0;
      error_q        <= 1'b0;
      img_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      stage_start_q  <= '0;
    end else begin
      state_q        <= state_d;
      stage_q        <= stage_d;
      addr_q         <= addr_d;
      result_q       <= result_d;
      error_q        <= error_d;
      img_valid_q    <= img_valid_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      stage_start_q  <= stage_start_d;
    end
  end

  assign bus.img_addr     = addr_q;
  assign bus.img_valid    = img_valid_q;
  assign bus.stage_start  = stage_start_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = busy_q;
  assign bus.error        = error_q;

endmodule

// File: tb/tb_cnn_sequencer.sv
// Directed bench for cnn_sequencer: a phase-level reference model checked
// every cycle, plus hand-computed cycle/value expectations per scenario.
module tb_cnn_sequencer;

  logic clk;
  logic rst_n;

  cnn_sequencer_if bus();

  cnn_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int c0       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus helpers ----------------
  logic [4:0] auto_done = '0;
  logic [4:0] man_done  = '0;
  logic [4:0] hang_mask = '0;
  logic [4:0] pend      = '0;
  logic       bp_ready  = 1'b1;
  int         rdy_mode  = 0;

  assign bus.stage_done = auto_done | man_done;
  assign bus.img_ready  = (rdy_mode == 0) ? 1'b1 : bp_ready;

  // Stage responder: done one cycle after start unless that stage hangs;
  // alternating ready (low on odd cycles after start) for backpressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      auto_done = pend;
      pend      = bus.stage_start & ~hang_mask;
      bp_ready  = (((cyc - c0) % 2) == 0);
    end
  end

  // ---------------- event recorder (cycles relative to start) ----------------
  int stage_rel[5];
  int rv_rel, err_rel, last_rel, first_rel;

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 5; k++)
        if (bus.stage_start[k] && stage_rel[k] < 0) stage_rel[k] = cyc - c0;
      if (bus.result_valid && rv_rel < 0) rv_rel = cyc - c0;
      if (bus.error && err_rel < 0) err_rel = cyc - c0;
      if (bus.img_valid && bus.img_ready && bus.img_addr == 8'd255) last_rel = cyc - c0;
      if (bus.img_valid && bus.img_ready && bus.img_addr == 8'd0 && first_rel < 0) first_rel = cyc - c0;
    end
  end

  // ---------------- phase-level reference model ----------------
  localparam int M_IDLE = 0, M_LOAD = 1, M_STG = 2, M_STORE = 3, M_ERR = 4;
  int         m_mode   = M_IDLE;
  int         m_pix    = 0;   // pixels accepted so far in this load
  int         m_stg    = 0;   // stage being run
  bit         m_kick   = 0;   // start pulse cycle of m_stg
  int         m_waited = 0;   // WAIT cycles spent on m_stg
  logic [3:0] m_result = '0;
  bit         m_err    = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= M_IDLE; m_pix <= 0; m_stg <= 0; m_kick <= 0;
      m_waited <= 0; m_result <= '0; m_err <= 0;
    end else if (bus.abort) begin
      m_mode <= M_IDLE; m_pix <= 0; m_kick <= 0; m_err <= 0;
    end else begin
      case (m_mode)
        M_IDLE, M_ERR: if (bus.start) begin
          m_mode <= M_LOAD; m_pix <= 0; m_err <= 0;
        end
        M_LOAD: if (bus.img_ready) begin
          if (m_pix == 255) begin
            m_mode <= M_STG; m_stg <= 0; m_kick <= 1; m_pix <= 0;
          end else begin
            m_pix <= m_pix + 1;
          end
        end
        M_STG: begin
          if (m_kick) begin
            m_kick <= 0; m_waited <= 0;
          end else if (bus.stage_done[m_stg]) begin
            if (m_stg == 4) begin
              m_result <= bus.class_in; m_mode <= M_STORE;
            end else begin
              m_stg <= m_stg + 1; m_kick <= 1;
            end
          end else if (bus.timeout_cycles != 0 && m_waited + 1 == int'(bus.timeout_cycles)) begin
            m_mode <= M_ERR; m_err <= 1;
          end else begin
            m_waited <= m_waited + 1;
          end
        end
        M_STORE: m_mode <= M_IDLE;
        default: m_mode <= M_IDLE;
      endcase
    end
  end

  // Per-cycle comparison of all outputs against the model.
  initial begin
    logic [20:0] act_v, exp_v;
    logic [4:0]  exp_ss;
    forever begin
      @(negedge clk);
      exp_ss = (m_mode == M_STG && m_kick) ? (5'b00001 << m_stg) : 5'b0;
      exp_v  = {8'(m_pix), (m_mode == M_LOAD), exp_ss, m_result, (m_mode == M_STORE),
                (m_mode == M_LOAD || m_mode == M_STG || m_mode == M_STORE), m_err};
      act_v  = {bus.img_addr, bus.img_valid, bus.stage_start, bus.result,
                bus.result_valid, bus.busy, bus.error};
      check("cycle_outputs", 32'(act_v), 32'(exp_v));
    end
  end

  task automatic do_start();
    for (int k = 0; k < 5; k++) stage_rel[k] = -1;
    rv_rel = -1; err_rel = -1; last_rel = -1; first_rel = -1;
    bus.start = 1'b1;
    c0 = cyc;
    tick(1);
    bus.start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "bench timeout");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.timeout_cycles = '0; bus.class_in = '0;
    for (int k = 0; k < 5; k++) stage_rel[k] = -1;
    rv_rel = -1; err_rel = -1; last_rel = -1; first_rel = -1;
    tick(3);
    check("reset_outputs", 32'({bus.img_addr, bus.img_valid, bus.stage_start, bus.result,
          bus.result_valid, bus.busy, bus.error}), 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Nominal run, class 7.
    bus.class_in = 4'd7;
    do_start();
    check("nom_busy_rel1", 32'(bus.busy), 32'd1);
    tick(269);
    check("nom_first_addr", first_rel, 1);
    check("nom_last_addr", last_rel, 256);
    for (int k = 0; k < 5; k++) check("nom_stage_start", stage_rel[k], 257 + 2 * k);
    check("nom_result_valid_cyc", rv_rel, 267);
    check("nom_result", 32'(bus.result), 32'd7);
    check("nom_busy_after", 32'(bus.busy), 32'd0);

    // Backpressure: ready every other cycle.
    rdy_mode = 1;
    bus.class_in = 4'd2;
    do_start();
    tick(540);
    check("bp_last_addr", last_rel, 512);
    check("bp_stage0", stage_rel[0], 513);
    check("bp_result_valid_cyc", rv_rel, 523);
    check("bp_result", 32'(bus.result), 32'd2);
    rdy_mode = 0;

    // Watchdog: stage 2 hangs, limit 10 WAIT cycles.
    bus.timeout_cycles = 16'd10;
    hang_mask = 5'b00100;
    bus.class_in = 4'd1;
    do_start();
    tick(300);
    check("wd_stage2", stage_rel[2], 261);
    check("wd_error_cyc", err_rel, 261 + 11);
    check("wd_no_stage3", stage_rel[3], -1);
    check("wd_error_flag", 32'(bus.error), 32'd1);
    check("wd_busy", 32'(bus.busy), 32'd0);
    check("wd_result_kept", 32'(bus.result), 32'd2);
    hang_mask = 5'b0;
    bus.class_in = 4'd5;
    do_start();
    check("wd_restart_error", 32'(bus.error), 32'd0);
    check("wd_restart_addr", 32'(bus.img_addr), 32'd0);
    tick(269);
    check("wd_restart_result", 32'(bus.result), 32'd5);
    check("wd_restart_rv_cyc", rv_rel, 267);

    // Spurious done bits while waiting on stage 1.
    bus.timeout_cycles = 16'd0;
    hang_mask = 5'b00010;
    bus.class_in = 4'd9;
    do_start();
    tick(260);
    man_done = 5'b01000;
    tick(1);
    man_done = 5'b00001;
    tick(1);
    man_done = 5'b0;
    tick(2);
    check("spur_still_waiting", stage_rel[2], -1);
    check("spur_busy", 32'(bus.busy), 32'd1);
    man_done = 5'b00010;
    tick(1);
    man_done = 5'b0;
    tick(10);
    hang_mask = 5'b0;
    check("spur_stage2", stage_rel[2], 266);
    check("spur_rv_cyc", rv_rel, 272);
    check("spur_result", 32'(bus.result), 32'd9);

    // Abort coincident with the final done; start while busy is ignored.
    hang_mask = 5'b10000;
    bus.class_in = 4'd3;
    do_start();
    tick(49);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(215);
    man_done = 5'b10000;
    bus.abort = 1'b1;
    tick(1);
    man_done = 5'b0;
    bus.abort = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_result_kept", 32'(bus.result), 32'd9);
    tick(3);
    check("abort_no_rv", rv_rel, -1);
    check("abort_stage0_unmoved", stage_rel[0], 257);
    check("abort_stage4", stage_rel[4], 265);
    hang_mask = 5'b0;

    // Asynchronous reset in the middle of the load.
    bus.class_in = 4'd4;
    do_start();
    for (int i = 0; i < 300 && bus.img_addr != 8'd100; i++) tick(1);
    check("rst_reach_addr100", 32'(bus.img_addr), 32'd100);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", 32'({bus.img_addr, bus.img_valid, bus.stage_start, bus.result,
          bus.result_valid, bus.busy, bus.error}), 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    do_start();
    check("rst_restart_addr", 32'(bus.img_addr), 32'd0);
    tick(269);
    check("rst_restart_result", 32'(bus.result), 32'd4);
    check("rst_restart_rv_cyc", rv_rel, 267);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
